// File: rtl/ddr_rd_tracker.sv
// ddr_rd_tracker: issues tagged read requests to a DDR controller command
// port and steers the returned read beats to one of two channels, using an
// in-order tag store that tracks every read still in flight.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cmd_valid/addr/tag         read request from the arbiter (tag 0 = ch0, 1 = ch1)
//   o_cmd_ready                  request accepted when high with i_cmd_valid
//   o_ddr_cmd_en/o_ddr_addr      read command to the DDR controller
//   i_ddr_cmd_rdy                controller accepts the command
//   i_ddr_rd_valid/end/data      returned read beats (end marks last beat of a burst)
//   o_ch0_valid/o_ch1_valid      beat qualifier per channel, 1 cycle after the input beat
//   o_rd_data                    registered read data shared by both channels
//   o_outstanding/full/empty     reads issued but not yet completed, and its flags
//   o_err                        sticky: a beat arrived with nothing outstanding
module ddr_rd_tracker #(
  parameter int unsigned PTR_W  = 8,
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic              i_cmd_tag,
  output logic              o_cmd_ready,
  output logic              o_ddr_cmd_en,
  output logic [ADDR_W-1:0] o_ddr_addr,
  input  logic              i_ddr_cmd_rdy,
  input  logic              i_ddr_rd_valid,
  input  logic              i_ddr_rd_end,
  input  logic [DATA_W-1:0] i_ddr_rd_data,
  output logic              o_ch0_valid,
  output logic              o_ch1_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [PTR_W:0]    o_outstanding,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_err
);

  localparam int unsigned DEPTH = 1 << PTR_W;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_tag;
  logic                r_store [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                r_cmd_ready;
  logic                w_cmd_ready_nxt;
  logic                r_full;
  logic                r_empty;
  logic                r_ch0_valid;
  logic                r_ch1_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_err;
  logic                w_accept;
  logic                w_issue;
  logic                w_hit;
  logic                w_pop;
  logic                w_tag;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake strobes, count and ready lookahead
  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_issue         = 1'b0;
    w_count_nxt     = r_count;
    w_cmd_ready_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid && r_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_ddr_cmd_rdy) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    case ({w_issue, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
    // Ready is registered, so it is derived from the values the next cycle will hold
    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE) && (w_count_nxt != CNT_W'(DEPTH));
  end

  // Beats arriving with nothing outstanding are dropped and flagged
  assign w_hit = i_ddr_rd_valid && !r_empty;
  assign w_pop = w_hit && i_ddr_rd_end;
  assign w_tag = r_store[r_rd_ptr];

  // Tag store: contents are not reset; pointers and count qualify them
  always_ff @(posedge i_clk) begin
    if (w_issue) begin
      r_store[r_wr_ptr] <= r_tag;
    end
  end

  // Command latch, pointers, count/flags and completion outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_tag       <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_ch0_valid <= 1'b0;
      r_ch1_valid <= 1'b0;
      r_rd_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= i_cmd_addr;
        r_tag  <= i_cmd_tag;
      end
      if (w_issue) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count     <= w_count_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_full      <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty     <= (w_count_nxt == CNT_W'(0));
      r_ch0_valid <= w_hit && !w_tag;
      r_ch1_valid <= w_hit && w_tag;
      if (w_hit) begin
        r_rd_data <= i_ddr_rd_data;
      end
      if (i_ddr_rd_valid && r_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_ddr_cmd_en  = (r_state == ST_ISSUE);
  assign o_ddr_addr    = r_addr;
  assign o_ch0_valid   = r_ch0_valid;
  assign o_ch1_valid   = r_ch1_valid;
  assign o_rd_data     = r_rd_data;
  assign o_outstanding = r_count;
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_err         = r_err;

endmodule

// File: tb/tb_ddr_rd_tracker.sv
// Testbench for ddr_rd_tracker: a hand-derived vector table for the basic
// single-read flow, then directed and random sequences checked against a
// queue-based reference model of the outstanding reads.
module tb_ddr_rd_tracker;

  localparam int unsigned PTR_W  = 8;
  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_tag;
  logic              cmd_ready;
  logic              ddr_cmd_en;
  logic [ADDR_W-1:0] ddr_addr;
  logic              ddr_cmd_rdy;
  logic              rd_valid;
  logic              rd_end;
  logic [DATA_W-1:0] rd_data;
  logic              ch0_valid;
  logic              ch1_valid;
  logic [DATA_W-1:0] o_data;
  logic [PTR_W:0]    outstanding;
  logic              full;
  logic              empty;
  logic              err;

  always #5 clk = ~clk;

  ddr_rd_tracker #(.PTR_W(PTR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .i_cmd_addr(cmd_addr), .i_cmd_tag(cmd_tag),
    .o_cmd_ready(cmd_ready), .o_ddr_cmd_en(ddr_cmd_en), .o_ddr_addr(ddr_addr),
    .i_ddr_cmd_rdy(ddr_cmd_rdy), .i_ddr_rd_valid(rd_valid), .i_ddr_rd_end(rd_end),
    .i_ddr_rd_data(rd_data), .o_ch0_valid(ch0_valid), .o_ch1_valid(ch1_valid),
    .o_rd_data(o_data), .o_outstanding(outstanding), .o_full(full),
    .o_empty(empty), .o_err(err)
  );

  int errors = 0;
  int checks = 0;
  int n_ch0  = 0;
  int n_ch1  = 0;

  // Reference model: queue of tags for reads in flight plus a pending command
  bit                m_q[$];
  bit                m_pend;
  logic [ADDR_W-1:0] m_addr;
  bit                m_tag;
  bit                m_ready;
  bit                m_err;
  bit                m_ch0;
  bit                m_ch1;
  logic [DATA_W-1:0] m_data;

  typedef struct {
    bit                rst;
    bit                cv;
    logic [ADDR_W-1:0] addr;
    bit                tag;
    bit                rdy;
    bit                rv;
    bit                re;
    logic [DATA_W-1:0] data;
    bit                e_ready;
    bit                e_en;
    logic [ADDR_W-1:0] e_addr;
    bit                e_ch0;
    bit                e_ch1;
    int                e_out;
    bit                e_empty;
    bit                e_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic vec_t mk(input bit r, input bit cv, input logic [ADDR_W-1:0] a, input bit t,
                              input bit rdy, input bit rv, input bit re, input logic [DATA_W-1:0] d,
                              input bit er, input bit een, input logic [ADDR_W-1:0] ea,
                              input bit e0, input bit e1, input int eo, input bit ee, input bit eerr);
    vec_t v;
    v.rst = r; v.cv = cv; v.addr = a; v.tag = t; v.rdy = rdy; v.rv = rv; v.re = re; v.data = d;
    v.e_ready = er; v.e_en = een; v.e_addr = ea; v.e_ch0 = e0; v.e_ch1 = e1;
    v.e_out = eo; v.e_empty = ee; v.e_err = eerr;
    return v;
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_tag = 1'b0;
    ddr_cmd_rdy = 1'b0; rd_valid = 1'b0; rd_end = 1'b0; rd_data = '0;
  endtask

  // Advance the model by one clock edge from the inputs currently applied
  task automatic model_edge();
    bit acc, iss, hit;
    if (rst) begin
      m_q.delete();
      m_pend = 1'b0; m_addr = '0; m_tag = 1'b0; m_ready = 1'b0; m_err = 1'b0;
      m_ch0 = 1'b0; m_ch1 = 1'b0; m_data = '0;
    end else begin
      iss = m_pend && ddr_cmd_rdy;
      acc = !m_pend && m_ready && cmd_valid;
      hit = rd_valid && (m_q.size() != 0);
      m_ch0 = 1'b0;
      m_ch1 = 1'b0;
      if (hit) begin
        m_ch0  = !m_q[0];
        m_ch1  = m_q[0];
        m_data = rd_data;
        if (rd_end) void'(m_q.pop_front());
      end else if (rd_valid) begin
        m_err = 1'b1;
      end
      if (iss) begin
        m_q.push_back(m_tag);
        m_pend = 1'b0;
      end
      if (acc) begin
        m_pend = 1'b1;
        m_addr = cmd_addr;
        m_tag  = cmd_tag;
      end
      m_ready = !m_pend && (m_q.size() < DEPTH);
    end
  endtask

  // One clock with full comparison against the model
  task automatic step();
    bit was_rst;
    was_rst = rst;
    model_edge();
    @(posedge clk);
    #1;
    chk("cmd_ready", cmd_ready, m_ready);
    chk("ddr_cmd_en", ddr_cmd_en, m_pend);
    if (m_pend || was_rst) chk("ddr_addr", ddr_addr, m_addr);
    chk("ch0_valid", ch0_valid, m_ch0);
    chk("ch1_valid", ch1_valid, m_ch1);
    if (m_ch0 || m_ch1 || was_rst) chk("rd_data", o_data, m_data);
    chk("outstanding", outstanding, m_q.size());
    chk("full", full, m_q.size() == DEPTH);
    chk("empty", empty, m_q.size() == 0);
    chk("err", err, m_err);
    if (ch0_valid) n_ch0++;
    if (ch1_valid) n_ch1++;
  endtask

  // Wait for the model to show ready, then request and issue immediately
  task automatic issue_one(input bit tag, input logic [ADDR_W-1:0] addr);
    int guard;
    guard = 0;
    idle_inputs();
    while (!m_ready && guard < 600) begin
      step();
      guard++;
    end
    if (guard >= 600) chk("issue_wait_timeout", 1, 0);
    cmd_valid = 1'b1; cmd_tag = tag; cmd_addr = addr; ddr_cmd_rdy = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] a5;
    int                tags[4];
    a5 = {32{8'hA5}};
    idle_inputs();
    rst = 1'b1;

    // rst cv addr tag rdy rv re data | ready en addr ch0 ch1 out empty err
    tbl[0] = mk(1, 0, 0,     0, 0, 0, 0, 0,        0, 0, 0,     0, 0, 0, 1, 0);
    tbl[1] = mk(0, 0, 0,     0, 0, 0, 0, 0,        1, 0, 0,     0, 0, 0, 1, 0);
    tbl[2] = mk(0, 1, 'h100, 1, 0, 0, 0, 0,        0, 1, 'h100, 0, 0, 0, 1, 0);
    tbl[3] = mk(0, 0, 0,     0, 1, 0, 0, 0,        1, 0, 0,     0, 0, 1, 0, 0);
    tbl[4] = mk(0, 0, 0,     0, 0, 1, 1, a5,       1, 0, 0,     0, 1, 0, 1, 0);
    tbl[5] = mk(0, 0, 0,     0, 0, 0, 0, 0,        1, 0, 0,     0, 0, 0, 1, 0);
    tbl[6] = mk(0, 0, 0,     0, 0, 1, 1, 'h77,     1, 0, 0,     0, 0, 0, 1, 1);
    tbl[7] = mk(0, 0, 0,     0, 0, 0, 0, 0,        1, 0, 0,     0, 0, 0, 1, 1);
    tbl[8] = mk(1, 0, 0,     0, 0, 0, 0, 0,        0, 0, 0,     0, 0, 0, 1, 0);

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; cmd_valid = tbl[i].cv; cmd_addr = tbl[i].addr; cmd_tag = tbl[i].tag;
      ddr_cmd_rdy = tbl[i].rdy; rd_valid = tbl[i].rv; rd_end = tbl[i].re; rd_data = tbl[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d cmd_ready", i), cmd_ready, tbl[i].e_ready);
      chk($sformatf("vec%0d ddr_cmd_en", i), ddr_cmd_en, tbl[i].e_en);
      if (tbl[i].e_en || tbl[i].rst) chk($sformatf("vec%0d ddr_addr", i), ddr_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d ch0_valid", i), ch0_valid, tbl[i].e_ch0);
      chk($sformatf("vec%0d ch1_valid", i), ch1_valid, tbl[i].e_ch1);
      chk($sformatf("vec%0d outstanding", i), outstanding, tbl[i].e_out);
      chk($sformatf("vec%0d full", i), full, 1'b0);
      chk($sformatf("vec%0d empty", i), empty, tbl[i].e_empty);
      chk($sformatf("vec%0d err", i), err, tbl[i].e_err);
      if (tbl[i].e_ch1) chk($sformatf("vec%0d rd_data", i), o_data, tbl[i].data);
      if (tbl[i].rst) chk($sformatf("vec%0d rd_data_rst", i), o_data, '0);
    end

    // Model-checked phase starts from a fresh reset
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Tags 0,1,1,0 with 4-beat bursts returned back-to-back
    tags = '{0, 1, 1, 0};
    for (int i = 0; i < 4; i++) issue_one(tags[i][0], ADDR_W'(32'h200 + i));
    n_ch0 = 0;
    n_ch1 = 0;
    for (int i = 0; i < 16; i++) begin
      rd_valid = 1'b1; rd_end = (i % 4 == 3); rd_data = rnd_data();
      step();
    end
    idle_inputs();
    step();
    chk("burst ch0 beats", n_ch0, 8);
    chk("burst ch1 beats", n_ch1, 8);

    // Controller back-pressure held for 10 cycles in ISSUE
    cmd_valid = 1'b1; cmd_addr = ADDR_W'(27'h5A5A5A5); cmd_tag = 1'b1;
    step();
    idle_inputs();
    repeat (10) step();
    ddr_cmd_rdy = 1'b1;
    step();
    idle_inputs();
    chk("stall release count", outstanding, 1);
    rd_valid = 1'b1; rd_end = 1'b1; rd_data = rnd_data();
    step();
    idle_inputs();
    step();

    // Fill all 256 entries, stall a 257th, free one entry, accept it
    for (int i = 0; i < 2 * DEPTH; i++) begin
      cmd_valid = 1'b1; ddr_cmd_rdy = 1'b1;
      cmd_tag = 1'($urandom); cmd_addr = ADDR_W'($urandom);
      step();
    end
    chk("full flag", full, 1);
    chk("full cmd_ready", cmd_ready, 0);
    repeat (5) step();
    chk("stalled while full", outstanding, DEPTH);
    rd_valid = 1'b1; rd_end = 1'b1; rd_data = rnd_data();
    step();
    rd_valid = 1'b0; rd_end = 1'b0;
    chk("full cleared", full, 0);
    step();
    step();
    idle_inputs();
    chk("257th accepted", outstanding, DEPTH);

    // Drain to 3 across the read-pointer wrap
    for (int i = 0; i < DEPTH - 3; i++) begin
      rd_valid = 1'b1; rd_end = 1'b1; rd_data = rnd_data();
      step();
    end
    idle_inputs();
    step();
    chk("drained to 3", outstanding, 3);

    // Acceptance and end beat in the same cycle
    cmd_valid = 1'b1; cmd_tag = 1'b0; cmd_addr = ADDR_W'(27'h123);
    step();
    cmd_valid = 1'b0; ddr_cmd_rdy = 1'b1;
    rd_valid = 1'b1; rd_end = 1'b1; rd_data = rnd_data();
    step();
    idle_inputs();
    chk("simultaneous push/pop", outstanding, 3);

    // Drain remaining reads as multi-beat bursts of random length
    while (m_q.size() != 0) begin
      for (int b = $urandom_range(3, 0); b >= 0; b--) begin
        rd_valid = 1'b1; rd_end = (b == 0); rd_data = rnd_data();
        step();
      end
    end
    idle_inputs();
    step();

    // Empty-return error, then reset in the middle of an issue
    rd_valid = 1'b1; rd_end = 1'b1; rd_data = rnd_data();
    step();
    idle_inputs();
    repeat (2) step();
    chk("err sticky", err, 1);
    cmd_valid = 1'b1; cmd_addr = ADDR_W'(27'h3FF); cmd_tag = 1'b1;
    step();
    idle_inputs();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset drops cmd_en", ddr_cmd_en, 0);
    chk("reset clears err", err, 0);
    step();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(299, 0) == 0);
      cmd_valid   = 1'($urandom);
      cmd_addr    = ADDR_W'($urandom);
      cmd_tag     = 1'($urandom);
      ddr_cmd_rdy = 1'($urandom);
      if (m_q.size() != 0) rd_valid = ($urandom_range(9, 0) < 7);
      else                 rd_valid = ($urandom_range(99, 0) < 3);
      rd_end  = ($urandom_range(9, 0) < 4);
      rd_data = rnd_data();
      step();
    end
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_rd_tracker.md
Name: ddr_rd_tracker

Overview:
- Issuing and completion side of back-to-back DDR read tracking.
- Accepts tagged read requests, issues each to the DDR controller command port, and records its 1-bit tag in an internal FIFO-ordered tag store.
- Pops tags in order as read data returns, and steers each returned beat to channel 0 (host/PCIe path) or channel 1 (user stream path).
- Sits between the read arbiter and the DDR controller native read interface.

Parameters:
- PTR_W, 8, tag-store pointer width; depth = 2^PTR_W outstanding reads (256).
- ADDR_W, 27, DDR command address width.
- DATA_W, 256, DDR read data width.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous active-high reset
- i_cmd_valid  input  1  read request valid
- i_cmd_addr  input  ADDR_W  read request address
- i_cmd_tag  input  1  destination tag: 0 = channel 0, 1 = channel 1
- o_cmd_ready  output  1  request accepted when high together with i_cmd_valid
- o_ddr_cmd_en  output  1  read command to DDR controller
- o_ddr_addr  output  ADDR_W  read command address
- i_ddr_cmd_rdy  input  1  DDR controller accepts command
- i_ddr_rd_valid  input  1  returned read data beat valid
- i_ddr_rd_end  input  1  last beat of the current read's burst
- i_ddr_rd_data  input  DATA_W  returned read data
- o_ch0_valid  output  1  beat for channel 0
- o_ch1_valid  output  1  beat for channel 1
- o_rd_data  output  DATA_W  registered read data, shared by both channels
- o_outstanding  output  PTR_W+1  number of reads issued but not yet completed
- o_full  output  1  o_outstanding == 2^PTR_W
- o_empty  output  1  o_outstanding == 0
- o_err  output  1  sticky: a beat arrived while o_empty was high

Behaviour:
- Reset (i_rst high at a clock edge):
  - Outputs: o_cmd_ready=0, o_ddr_cmd_en=0, o_ddr_addr=0, o_ch0_valid=0, o_ch1_valid=0, o_rd_data=0, o_outstanding=0, o_full=0, o_empty=1, o_err=0.
  - Internal: wr_ptr=0, rd_ptr=0, state=IDLE.
  - Tag-store contents are not reset.
  - Reset mid-issue abandons the latched command; o_ddr_cmd_en drops in the cycle after the reset edge.
- Issue FSM, IDLE:
  - o_cmd_ready = !o_full (registered view of the count).
  - On i_cmd_valid && o_cmd_ready: latch addr and tag, go to ISSUE.
- Issue FSM, ISSUE:
  - o_cmd_ready=0, o_ddr_cmd_en=1, o_ddr_addr holds the latched addr.
  - On i_ddr_cmd_rdy: write the latched tag to store[wr_ptr], wr_ptr+1 (wraps modulo 2^PTR_W), go to IDLE.
  - Commands are issued at most once every 2 cycles.
  - Latched addr and tag remain stable while i_ddr_cmd_rdy is low; no timeout.
- Completion path:
  - On i_ddr_rd_valid with o_outstanding != 0: tag = store[rd_ptr] (asynchronous read).
  - Next cycle: o_rd_data = i_ddr_rd_data; o_ch0_valid = !tag; o_ch1_valid = tag. Latency is exactly 1 cycle.
  - If i_ddr_rd_end is also high, rd_ptr+1 (wraps).
  - Multi-beat bursts keep the same tag until the end beat.
- Empty-return error:
  - i_ddr_rd_valid while o_outstanding == 0: beat dropped, both channel valids stay 0, rd_ptr unchanged.
  - o_err sets and holds until reset.
- Count rules:
  - +1 on command acceptance in ISSUE (i_ddr_cmd_rdy).
  - -1 on an end beat consumed.
  - Both in the same cycle: unchanged.
- Write/read overlap:
  - Tag write and tag read of the same entry in the same cycle occurs only when count == 0.
  - In that case the beat is an error and the read result is don't-care.
- Ptr wrap:
  - wr_ptr == rd_ptr with count == 2^PTR_W means full.
  - With count == 0 it means empty; the count disambiguates.
- Flags: o_full and o_empty are registered from the updated count, with the same timing as o_outstanding.

Test Plan:
- Reset, then request addr=0x100 tag=1 with i_ddr_cmd_rdy=1 → o_ddr_cmd_en high for 1 cycle with o_ddr_addr=0x100, o_outstanding=1; then one beat 0xA5.. with end → o_ch1_valid=1 and o_rd_data=0xA5.. next cycle, o_outstanding=0, o_empty=1.
- Issue tags 0,1,1,0 with 4-beat bursts returning back-to-back → 4 ch0 beats, 8 ch1 beats, 4 ch0 beats in order, each 1 cycle after input.
- Hold i_ddr_cmd_rdy=0 for 10 cycles in ISSUE → o_ddr_cmd_en and o_ddr_addr stable, o_cmd_ready=0; release → single acceptance, count+1.
- Issue 256 reads with no returns → o_full=1, o_cmd_ready=0 and a 257th request is stalled; one end beat → o_full=0 next cycle, 257th accepted; wr_ptr has wrapped to 0.
- Command acceptance and end beat in the same cycle with count=3 → count stays 3; tag routing is correct across the rd_ptr wrap 255→0.
- Beat with o_empty=1 → no channel valid, o_err=1 and held; assert i_rst mid-ISSUE → all outputs at reset values, o_err=0.
